load_wb_ctrl: RTL and testbench
===============================

# load_wb_ctrl

Multi-cycle load sequencer for the MEM/WB boundary of the pipeline. It accepts a load from the MEM stage and issues a request/acknowledge transaction to data memory. While the memory is busy it stalls the pipeline. It captures the returned word and drives the select and data inputs of the writeback load-source mux for exactly one cycle, when the load occupies WB.

## Interface
- `TIMEOUT`, default 15: REQ cycles without `dm_ack` before abort (used only with the macro).
- `CNT_W`, default 4: timeout counter width; must satisfy `TIMEOUT` < 2^`CNT_W`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `ld_valid` in 1: a load instruction is in MEM this cycle.
- `ld_addr` in `RegBus: effective address of that load.
- `flush` in 1: pipeline flush; abort any in-flight load.
- `dm_req` out 1: data-memory read request; registered.
- `dm_addr` out `RegBus: request address; registered, held stable while `dm_req`=1.
- `dm_ack` in 1: data memory has `dm_rdata` valid; sampled only in REQ.
- `dm_rdata` in `RegBus: read data.
- `stall` out 1: freeze IF..MEM; combinational.
- `lwsrc_sel` out 1: load-source mux select, 0 = ALU result, 1 = `ld_data`; registered.
- `ld_data` out `RegBus: captured load word, wired to mux input I1; registered.
- `ld_err` out 1: one-cycle timeout error pulse; registered.

## Operation
- The FSM has three states: IDLE, REQ and RESP. It resets to IDLE.
- **IDLE**
  - `stall` = `ld_valid`.
  - If `ld_valid`=1 and `flush`=0:
    - latch `ld_addr` into `dm_addr`;
    - set `dm_req`=1;
    - go to REQ.
  - `dm_ack` is ignored in IDLE.
- **REQ**
  - `stall`=1 and `dm_req`=1.
  - On `dm_ack`=1:
    - `ld_data` <= `dm_rdata`;
    - `dm_req` <= 0;
    - go to RESP.
  - `ld_valid` and `ld_addr` are ignored (the stalled load is still in MEM).
- **RESP**
  - `stall`=0, so the load leaves MEM at the end of this cycle.
  - `lwsrc_sel` <= 1.
  - Go to IDLE.
  - `ld_valid` is ignored in this cycle.
- **`lwsrc_sel`**
  - High for exactly the one cycle after RESP, which is the load's WB cycle.
  - Otherwise 0.
- **`ld_data`** changes only on `dm_ack` in REQ, so it holds the previous word throughout its WB cycle. This holds even when a back-to-back load enters REQ in that same cycle.
- **`flush`**
  - In REQ or RESP: go to IDLE next cycle, `dm_req` <= 0, no `lwsrc_sel` pulse, `ld_data` unchanged.
  - `flush` takes priority over `dm_ack`.
  - In IDLE: no request starts.
- **Reset mid-operation** forces the reset values immediately; any outstanding memory response is dropped.
- **Reset values:**
  - state IDLE;
  - `dm_req`=0, `dm_addr`=0;
  - `ld_data`=0, `lwsrc_sel`=0, `ld_err`=0;
  - `stall` follows `ld_valid`.

## Timing
- `ld_valid` is seen in IDLE at cycle 0.
- `dm_req`=1 from cycle 1 until the cycle `dm_ack` is sampled, at cycle k ≥ 1.
- RESP occurs at k+1; `lwsrc_sel`=1 at k+2.
- `stall`=1 for cycles 0..k, giving a minimum stall of 2 cycles (ack in cycle 1).
- Load-to-WB latency is k+2 cycles.
- Back-to-back loads: the next `ld_valid` is accepted in the `lwsrc_sel` cycle (IDLE), and its `dm_req` rises the following cycle.

## Configuration
- `LOAD_WB_CTRL_TIMEOUT_EN` defined:
  - a `CNT_W`-bit counter clears on REQ entry and increments each REQ cycle without `dm_ack`;
  - when it reaches `TIMEOUT` without `dm_ack`: `ld_err` pulses 1 for one cycle, `dm_req` <= 0, go to IDLE, no `lwsrc_sel`, `ld_data` unchanged;
  - `dm_ack` in that same cycle wins over the timeout.
- `LOAD_WB_CTRL_TIMEOUT_EN` undefined:
  - no counter;
  - REQ waits indefinitely;
  - `ld_err` is tied to 0.

## Test plan
- Reset low, then high, with `ld_valid`=0 → all outputs 0 and state IDLE.
- `ld_valid`=1, `ld_addr`=0x100 at cycle 0; `dm_ack` at cycle 3 with `dm_rdata`=0xDEADBEEF → `dm_req` high cycles 1-3 with `dm_addr`=0x100; `stall` high cycles 0-3; `lwsrc_sel`=1 only at cycle 5 with `ld_data`=0xDEADBEEF.
- Two back-to-back loads, addresses 0x10 then 0x14, each acked 1 cycle after request → second `dm_req` rises in the cycle after the first `lwsrc_sel` pulse; `ld_data` is 0x…(word@0x10) through the first WB cycle and is then replaced by word@0x14.
- `flush` in the second REQ cycle with `dm_ack`=1 the same cycle → `dm_req`=0 next cycle, no `lwsrc_sel` pulse, `ld_data` unchanged.
- With `LOAD_WB_CTRL_TIMEOUT_EN` defined, `TIMEOUT`=15 and no `dm_ack` → `ld_err` pulses once after 15 REQ cycles, `stall` drops, and state returns to IDLE. Without the macro, `dm_req` stays high for more than 100 cycles and `ld_err` stays 0.
- Async reset asserted mid-REQ between clock edges → `dm_req`, `lwsrc_sel` and `ld_data` go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/load_wb_ctrl_if.sv
// Handshake bundle between MEM/WB pipeline, load sequencer and data memory.
// master = pipeline/memory side, slave = load_wb_ctrl.
`ifndef RegBus
`define RegBus 31:0
`endif

interface load_wb_ctrl_if;
    logic          ld_valid;
    logic [`RegBus] ld_addr;
    logic          flush;
    logic          dm_req;
    logic [`RegBus] dm_addr;
    logic          dm_ack;
    logic [`RegBus] dm_rdata;
    logic          stall;
    logic          lwsrc_sel;
    logic [`RegBus] ld_data;
    logic          ld_err;

    modport slave (
        input  ld_valid, ld_addr, flush, dm_ack, dm_rdata,
        output dm_req, dm_addr, stall, lwsrc_sel, ld_data, ld_err
    );

    modport master (
        output ld_valid, ld_addr, flush, dm_ack, dm_rdata,
        input  dm_req, dm_addr, stall, lwsrc_sel, ld_data, ld_err
    );
endinterface

// File: rtl/load_wb_ctrl.sv
// Multi-cycle load sequencer at the MEM/WB boundary: IDLE -> REQ -> RESP.
// Optional REQ timeout with ld_err pulse enabled by LOAD_WB_CTRL_TIMEOUT_EN.
`ifndef RegBus
`define RegBus 31:0
`endif

module load_wb_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    load_wb_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    if (TIMEOUT >= (1 << CNT_W)) begin : g_cfg_bad
        $error("load_wb_ctrl: TIMEOUT must be below 2**CNT_W");
    end

    logic [1:0]     state;
    logic           dm_req_q;
    logic [`RegBus] dm_addr_q;
    logic [`RegBus] ld_data_q;
    logic           lwsrc_q;
    logic           ld_err_q;

`ifdef LOAD_WB_CTRL_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            dm_req_q  <= 1'b0;
            dm_addr_q <= '0;
            ld_data_q <= '0;
            lwsrc_q   <= 1'b0;
            ld_err_q  <= 1'b0;
`ifdef LOAD_WB_CTRL_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            lwsrc_q  <= 1'b0;
            ld_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ld_valid && !bus.flush) begin
                        dm_addr_q <= bus.ld_addr;
                        dm_req_q  <= 1'b1;
                        state     <= REQ;
`ifdef LOAD_WB_CTRL_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end
                end
                REQ: begin
                    // flush outranks a same-cycle ack so a squashed load never writes back
                    if (bus.flush) begin
                        dm_req_q <= 1'b0;
                        state    <= IDLE;
                    end else if (bus.dm_ack) begin
                        ld_data_q <= bus.dm_rdata;
                        dm_req_q  <= 1'b0;
                        state     <= RESP;
                    end
`ifdef LOAD_WB_CTRL_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        ld_err_q <= 1'b1;
                        dm_req_q <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                    if (!bus.flush) lwsrc_q <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    dm_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.stall = 1'b0;
        case (state)
            IDLE:    bus.stall = bus.ld_valid;
            REQ:     bus.stall = 1'b1;
            default: bus.stall = 1'b0;
        endcase
    end

    assign bus.dm_req    = dm_req_q;
    assign bus.dm_addr   = dm_addr_q;
    assign bus.ld_data   = ld_data_q;
    assign bus.lwsrc_sel = lwsrc_q;
`ifdef LOAD_WB_CTRL_TIMEOUT_EN
    assign bus.ld_err    = ld_err_q;
`else
    assign bus.ld_err    = 1'b0;
`endif

endmodule

// File: tb/tb_load_wb_ctrl.sv
// Directed bench for load_wb_ctrl: reset, single load, back-to-back, flush,
// REQ timeout / indefinite wait, and asynchronous reset mid-REQ.
module tb_load_wb_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    load_wb_ctrl_if bus ();

    load_wb_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.flush    = 1'b0;
        bus.dm_ack   = 1'b0;
        bus.dm_rdata = '0;

        // reset
        #2;
        bus.ld_valid = 1'b1;
        #1;
        chk("rst_stall_follows", {31'd0, bus.stall}, 32'd1);
        bus.ld_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_dm_req",   {31'd0, bus.dm_req},    32'd0);
        chk("rst_dm_addr",  bus.dm_addr,            32'd0);
        chk("rst_ld_data",  bus.ld_data,            32'd0);
        chk("rst_lwsrc",    {31'd0, bus.lwsrc_sel}, 32'd0);
        chk("rst_ld_err",   {31'd0, bus.ld_err},    32'd0);
        chk("rst_stall",    {31'd0, bus.stall},     32'd0);

        // single load, ack at cycle 3
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h100;            // cycle 0
        #1;
        chk("s_c0_stall",  {31'd0, bus.stall},  32'd1);
        chk("s_c0_dm_req", {31'd0, bus.dm_req}, 32'd0);
        tick();                                                 // cycle 1
        chk("s_c1_dm_req",  {31'd0, bus.dm_req}, 32'd1);
        chk("s_c1_dm_addr", bus.dm_addr,         32'h100);
        chk("s_c1_stall",   {31'd0, bus.stall},  32'd1);
        bus.ld_addr = 32'h999;                                  // ignored in REQ
        tick();                                                 // cycle 2
        chk("s_c2_dm_req",  {31'd0, bus.dm_req}, 32'd1);
        chk("s_c2_dm_addr", bus.dm_addr,         32'h100);
        tick();                                                 // cycle 3
        bus.dm_ack = 1'b1; bus.dm_rdata = 32'hDEADBEEF;
        #1;
        chk("s_c3_dm_req", {31'd0, bus.dm_req}, 32'd1);
        chk("s_c3_stall",  {31'd0, bus.stall},  32'd1);
        tick();                                                 // cycle 4 RESP
        bus.dm_ack = 1'b0;
        #1;
        chk("s_c4_dm_req", {31'd0, bus.dm_req},    32'd0);
        chk("s_c4_stall",  {31'd0, bus.stall},     32'd0);
        chk("s_c4_lwsrc",  {31'd0, bus.lwsrc_sel}, 32'd0);
        tick();                                                 // cycle 5 WB
        bus.ld_valid = 1'b0;
        chk("s_c5_lwsrc",   {31'd0, bus.lwsrc_sel}, 32'd1);
        chk("s_c5_ld_data", bus.ld_data,            32'hDEADBEEF);
        tick();                                                 // cycle 6
        chk("s_c6_lwsrc",  {31'd0, bus.lwsrc_sel}, 32'd0);
        chk("s_c6_dm_req", {31'd0, bus.dm_req},    32'd0);

        // back-to-back loads 0x10 then 0x14, ack in first REQ cycle
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h10;              // cycle 0
        tick();                                                 // cycle 1 REQ
        chk("b_c1_dm_addr", bus.dm_addr, 32'h10);
        bus.dm_ack = 1'b1; bus.dm_rdata = 32'hA0A00010;
        tick();                                                 // cycle 2 RESP
        bus.dm_ack = 1'b0;
        chk("b_c2_dm_req", {31'd0, bus.dm_req}, 32'd0);
        tick();                                                 // cycle 3 WB A, IDLE
        chk("b_c3_lwsrc",   {31'd0, bus.lwsrc_sel}, 32'd1);
        chk("b_c3_ld_data", bus.ld_data,            32'hA0A00010);
        bus.ld_addr = 32'h14;
        #1;
        chk("b_c3_stall",  {31'd0, bus.stall},  32'd1);
        chk("b_c3_dm_req", {31'd0, bus.dm_req}, 32'd0);
        tick();                                                 // cycle 4 REQ B
        chk("b_c4_dm_req",  {31'd0, bus.dm_req},    32'd1);
        chk("b_c4_dm_addr", bus.dm_addr,            32'h14);
        chk("b_c4_lwsrc",   {31'd0, bus.lwsrc_sel}, 32'd0);
        chk("b_c4_ld_data", bus.ld_data,            32'hA0A00010);
        bus.dm_ack = 1'b1; bus.dm_rdata = 32'hB0B00014;
        tick();                                                 // cycle 5 RESP B
        bus.dm_ack = 1'b0;
        chk("b_c5_ld_data", bus.ld_data, 32'hB0B00014);
        tick();                                                 // cycle 6 WB B
        bus.ld_valid = 1'b0;
        chk("b_c6_lwsrc", {31'd0, bus.lwsrc_sel}, 32'd1);
        tick();

        // flush in second REQ cycle with ack the same cycle
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h200;             // cycle 0
        tick();                                                 // cycle 1
        tick();                                                 // cycle 2
        bus.flush = 1'b1; bus.dm_ack = 1'b1; bus.dm_rdata = 32'h12345678;
        tick();                                                 // cycle 3
        bus.flush = 1'b0; bus.dm_ack = 1'b0; bus.ld_valid = 1'b0;
        #1;
        chk("f_c3_dm_req",  {31'd0, bus.dm_req},    32'd0);
        chk("f_c3_stall",   {31'd0, bus.stall},     32'd0);
        chk("f_c3_ld_data", bus.ld_data,            32'hB0B00014);
        tick();                                                 // cycle 4
        chk("f_c4_lwsrc",   {31'd0, bus.lwsrc_sel}, 32'd0);
        chk("f_c4_ld_data", bus.ld_data,            32'hB0B00014);

        // flush in IDLE blocks a request
        bus.ld_valid = 1'b1; bus.flush = 1'b1; bus.ld_addr = 32'h300;
        tick();
        bus.ld_valid = 1'b0; bus.flush = 1'b0;
        chk("fi_dm_req",  {31'd0, bus.dm_req}, 32'd0);
        chk("fi_dm_addr", bus.dm_addr,         32'h200);
        tick();

        // no ack: timeout or indefinite wait
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h400;             // cycle 0
`ifdef LOAD_WB_CTRL_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("t_req_hold", {31'd0, bus.dm_req}, 32'd1);
            chk("t_err_low",  {31'd0, bus.ld_err}, 32'd0);
        end
        tick();                                                 // cycle 16
        bus.ld_valid = 1'b0;
        #1;
        chk("t_err_pulse", {31'd0, bus.ld_err},    32'd1);
        chk("t_dm_req",    {31'd0, bus.dm_req},    32'd0);
        chk("t_stall",     {31'd0, bus.stall},     32'd0);
        chk("t_ld_data",   bus.ld_data,            32'hB0B00014);
        tick();
        chk("t_err_once",  {31'd0, bus.ld_err},    32'd1 - 32'd1);
        chk("t_lwsrc",     {31'd0, bus.lwsrc_sel}, 32'd0);
        chk("t_idle_req",  {31'd0, bus.dm_req},    32'd0);
`else
        for (int i = 1; i <= 110; i++) begin
            tick();
            chk("w_req_hold", {31'd0, bus.dm_req}, 32'd1);
            chk("w_err_low",  {31'd0, bus.ld_err}, 32'd0);
        end
        bus.ld_valid = 1'b0; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("w_flush_req", {31'd0, bus.dm_req}, 32'd0);
        chk("w_lwsrc",     {31'd0, bus.lwsrc_sel}, 32'd0);
`endif
        tick();

        // async reset between edges while in REQ
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h500;
        tick();
        tick();
        chk("a_pre_req", {31'd0, bus.dm_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("a_dm_req",  {31'd0, bus.dm_req},    32'd0);
        chk("a_lwsrc",   {31'd0, bus.lwsrc_sel}, 32'd0);
        chk("a_ld_data", bus.ld_data,            32'd0);
        chk("a_dm_addr", bus.dm_addr,            32'd0);
        bus.ld_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("a_post_req", {31'd0, bus.dm_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
